counter_updown_mod: RTL and testbench



---
 rtl/counter_pkg.sv | 27 ++
 rtl/counter_prescaler.sv | 50 +++++
 rtl/counter_updown_mod.sv | 154 +++++++++++++++
 tb/tb_counter_updown_mod.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared constants and helpers for the counter_updown_mod family.
//   - DIR_UP / DIR_DOWN       : encoding of the up_down input.
//   - MODE_WRAP / MODE_SATURATE : values of the SATURATE parameter.
//   - clog2()                 : elaboration-time ceil(log2) used to size the
//                               prescaler phase register.
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;

    // Smallest n with 2**n >= value; value >= 2 always yields at least 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
//   Divides enable-high cycles by DIV. The phase register advances only on
//   enable cycles and wraps after DIV-1; tick is asserted combinationally on
//   the enable cycle in which the phase sits at DIV-1, so the owning counter
//   steps on that same edge with no added latency.
//
// Parameters:
//   DIV     : divide ratio (>= 2).
// Ports:
//   clk     : rising-edge clock.
//   reset   : synchronous, active-high; zeroes the phase.
//   restart : synchronous; zeroes the phase (owner's clear/load).
//   enable  : count-step request; the phase is frozen while low.
//   tick    : step qualifier for the current cycle.
// -----------------------------------------------------------------------------
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int            PW   = clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] phase;

    assign tick = enable && (phase == LAST);

    // NOTE: clocked state is always written with <= so every flop samples the
    // pre-edge values of its inputs, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            phase <= '0;
        end else if (enable) begin
            if (phase == LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// -----------------------------------------------------------------------------
// counter_updown_mod
//   Generic up/down event/timer counter with a configurable modulo limit.
//   Count range is 0..MAX_VALUE. At a boundary the counter either wraps or
//   saturates (SATURATE); every boundary event pulses tc for one cycle and
//   sets the sticky overflow flag.
//
//   Edge priority: reset > clear > load > enable step.
//
// Optional build macro:
//   COUNTER_PRESCALE_EN : when defined, a step happens only on every
//                         PRESCALE_DIV-th enable-high cycle (counter_prescaler).
//                         When undefined, every enable-high cycle is a step and
//                         no prescaler flops exist.
//
// Parameters:
//   WIDTH        : counter width, 2..32.
//   MAX_VALUE    : highest count value (1..2**WIDTH-1).
//   INIT_VALUE   : value after reset and clear (<= MAX_VALUE).
//   SATURATE     : MODE_WRAP or MODE_SATURATE.
//   PRESCALE_DIV : enable divide ratio (>= 2), prescaled builds only.
// Ports:
//   clk        : rising-edge clock.
//   reset      : synchronous, active-high reset.
//   enable     : count-step request for this cycle.
//   up_down    : DIR_UP (1) counts up, DIR_DOWN (0) counts down.
//   clear      : synchronous clear to INIT_VALUE.
//   load       : synchronous load of load_value (clamped to MAX_VALUE).
//   load_value : value to load.
//   ovf_clear  : clears the overflow flag (a same-edge boundary event wins).
//   count      : current count, registered.
//   tc         : terminal-count pulse, registered.
//   overflow   : sticky boundary-event flag.
// -----------------------------------------------------------------------------
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] MAX_VALUE    = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] INIT_VALUE   = '0,
    parameter int               SATURATE     = MODE_WRAP,
    parameter int               PRESCALE_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clear,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             overflow
);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("counter_updown_mod: WIDTH must be in 2..32");
    end
    if (MAX_VALUE == '0) begin : g_bad_max_value
        $error("counter_updown_mod: MAX_VALUE must be >= 1");
    end
    if (INIT_VALUE > MAX_VALUE) begin : g_bad_init_value
        $error("counter_updown_mod: INIT_VALUE must be <= MAX_VALUE");
    end
    if (PRESCALE_DIV < 2) begin : g_bad_prescale_div
        $error("counter_updown_mod: PRESCALE_DIV must be >= 2");
    end

    localparam bit SAT_MODE = (SATURATE == MODE_SATURATE);

    logic             step;
    logic             boundary;
    logic [WIDTH-1:0] step_count;
    logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_PRESCALE_EN
    logic tick;

    counter_prescaler #(
        .DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .restart (clear | load),
        .enable  (enable),
        .tick    (tick)
    );

    assign step = tick;
`else
    assign step = enable;
`endif

    // Over-range loads clamp so count can never exceed MAX_VALUE.
    assign load_clamped = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;

    // Next count for a step, and whether that step hits a boundary. Limits are
    // MAX_VALUE and 0, never the natural 2**WIDTH roll-over.
    always_comb begin
        // NOTE: defaulting every output first guarantees each path assigns it,
        // so no latch is inferred.
        step_count = count;
        boundary   = 1'b0;
        case (up_down)
            DIR_UP: begin
                if (count == MAX_VALUE) begin
                    boundary   = 1'b1;
                    step_count = SAT_MODE ? MAX_VALUE : '0;
                end else begin
                    step_count = count + 1'b1;
                end
            end
            DIR_DOWN: begin
                if (count == '0) begin
                    boundary   = 1'b1;
                    step_count = SAT_MODE ? '0 : MAX_VALUE;
                end else begin
                    step_count = count - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= INIT_VALUE;
            tc       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // Cleared first; a boundary event further down overrides it on the
            // same edge because the later non-blocking assignment wins.
            if (ovf_clear) begin
                overflow <= 1'b0;
            end

            tc <= 1'b0;
            if (clear) begin
                count <= INIT_VALUE;
            end else if (load) begin
                count <= load_clamped;
            end else if (step) begin
                count <= step_count;
                if (boundary) begin
                    tc       <= 1'b1;
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_updown_mod.sv
// -----------------------------------------------------------------------------
// tb_counter_updown_mod
//   Two DUTs (WIDTH=4, MAX_VALUE=9, INIT_VALUE=0, PRESCALE_DIV=3), one in wrap
//   mode and one in saturate mode, share the same stimulus. For each driven
//   cycle an arithmetic reference model computes the post-edge state of both
//   and pushes it into a queue; an independent monitor pops one entry after
//   every rising edge and compares. Directed test-plan sequences are followed
//   by randomized traffic.
// -----------------------------------------------------------------------------
module tb_counter_updown_mod;

    localparam int WIDTH = 4;
    localparam int MAXV  = 9;
    localparam int INITV = 0;
    localparam int DIV   = 3;
    localparam int MODV  = MAXV + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             up_down = 1'b1;
    logic             clear = 1'b0;
    logic             load = 1'b0;
    logic             ovf_clear = 1'b0;
    logic [WIDTH-1:0] load_value = '0;

    logic [WIDTH-1:0] count_w, count_s;
    logic             tc_w, tc_s, ovf_w, ovf_s;

    always #5 clk = ~clk;

    counter_updown_mod #(
        .WIDTH(WIDTH), .MAX_VALUE(4'd9), .INIT_VALUE(4'd0),
        .SATURATE(0), .PRESCALE_DIV(DIV)
    ) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .ovf_clear(ovf_clear), .count(count_w), .tc(tc_w), .overflow(ovf_w)
    );

    counter_updown_mod #(
        .WIDTH(WIDTH), .MAX_VALUE(4'd9), .INIT_VALUE(4'd0),
        .SATURATE(1), .PRESCALE_DIV(DIV)
    ) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .ovf_clear(ovf_clear), .count(count_s), .tc(tc_s), .overflow(ovf_s)
    );

    typedef struct {
        int cnt_w;
        int cnt_s;
        bit tc_w;
        bit tc_s;
        bit ovf_w;
        bit ovf_s;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: index 0 = wrap DUT, index 1 = saturate DUT.
    int m_cnt[2];
    bit m_tc[2];
    bit m_ovf[2];
    int m_pre = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock edge of the specified behaviour, in plain integer arithmetic.
    task automatic model_edge(input bit rst, input bit clr, input bit ld, input bit en,
                              input bit ud, input bit oc, input int lv);
        bit step;
        bit ev;
        int nxt;
        step = en;
`ifdef COUNTER_PRESCALE_EN
        if (rst || clr || ld) begin
            m_pre = 0;
        end else if (en) begin
            step  = (m_pre == DIV - 1);
            m_pre = (m_pre + 1) % DIV;
        end
`endif
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                m_cnt[s] = INITV;
                m_tc[s]  = 1'b0;
                m_ovf[s] = 1'b0;
            end else begin
                ev = 1'b0;
                if (clr) begin
                    m_cnt[s] = INITV;
                end else if (ld) begin
                    m_cnt[s] = (lv > MAXV) ? MAXV : lv;
                end else if (step) begin
                    nxt = m_cnt[s] + (ud ? 1 : -1);
                    if (nxt < 0 || nxt > MAXV) begin
                        ev = 1'b1;
                        if (s == 0) m_cnt[s] = (nxt + MODV) % MODV;
                    end else begin
                        m_cnt[s] = nxt;
                    end
                end
                m_tc[s] = ev;
                if (ev) m_ovf[s] = 1'b1;
                else if (oc) m_ovf[s] = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then
    // return just after the rising edge has been issued.
    task automatic cycle(input bit rst, input bit clr, input bit ld, input bit en,
                         input bit ud, input bit oc, input int lv);
        exp_t e;
        @(negedge clk);
        reset      = rst;
        clear      = clr;
        load       = ld;
        enable     = en;
        up_down    = ud;
        ovf_clear  = oc;
        load_value = WIDTH'(lv);
        model_edge(rst, clr, ld, en, ud, oc, lv);
        e.cnt_w = m_cnt[0];
        e.cnt_s = m_cnt[1];
        e.tc_w  = m_tc[0];
        e.tc_s  = m_tc[1];
        e.ovf_w = m_ovf[0];
        e.ovf_s = m_ovf[1];
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic run(input bit en, input bit ud);
        cycle(1'b0, 1'b0, 1'b0, en, ud, 1'b0, 0);
    endtask

    task automatic do_load(input int lv);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, lv);
    endtask

    // Monitor: one expected entry per rising edge, compared 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wrap_count",    32'(count_w), 32'(e.cnt_w));
                check("wrap_tc",       32'(tc_w),    32'(e.tc_w));
                check("wrap_overflow", 32'(ovf_w),   32'(e.ovf_w));
                check("sat_count",     32'(count_s), 32'(e.cnt_s));
                check("sat_tc",        32'(tc_s),    32'(e.tc_s));
                check("sat_overflow",  32'(ovf_s),   32'(e.ovf_s));
            end
        end
    end

    initial begin
        // Reset for two cycles.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        #1;
        check("reset_count", 32'(count_w), 32'd0);
        check("reset_overflow", 32'(ovf_w), 32'd0);

        // Wrap up: 12 steps -> 1..9,0,1,2.
        for (int i = 0; i < 12; i++) run(1'b1, 1'b1);
        #1;
        check("wrap_up_end", 32'(count_w), 32'd2);
        check("wrap_up_ovf", 32'(ovf_w), 32'd1);

        // Wrap down from 0: 9,8,7.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) run(1'b1, 1'b0);
        #1;
        check("wrap_down_end", 32'(count_w), 32'd7);

        // Second 0->9 event together with ovf_clear: set wins.
        do_load(0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        #1;
        check("set_wins_ovf", 32'(ovf_w), 32'd1);
        check("set_wins_tc", 32'(tc_w), 32'd1);

        // Saturate: up from 7 for 5 steps -> 8,9,9,9,9.
        do_load(7);
        for (int i = 0; i < 5; i++) run(1'b1, 1'b1);
        #1;
        check("sat_hold_count", 32'(count_s), 32'd9);
        check("sat_hold_tc", 32'(tc_s), 32'd1);

        // Load priority and clamping.
        do_load(3);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7);
        #1;
        check("load_beats_step", 32'(count_w), 32'd7);
        check("load_tc", 32'(tc_w), 32'd0);
        do_load(15);
        #1;
        check("load_clamp", 32'(count_w), 32'd9);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5);
        #1;
        check("clear_beats_load", 32'(count_w), 32'd0);

        // Reset mid-operation with load and enable asserted.
        do_load(5);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7);
        #1;
        check("reset_mid_count", 32'(count_w), 32'd0);
        check("reset_mid_ovf", 32'(ovf_w), 32'd0);

        // Prescaler scenario (plain build: every enable cycle steps).
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 9; i++) run(1'b1, 1'b1);
        #1;
`ifdef COUNTER_PRESCALE_EN
        check("prescale_9_enables", 32'(count_w), 32'd3);
`else
        check("prescale_9_enables", 32'(count_w), 32'd9);
`endif
        for (int i = 0; i < 5; i++) begin
            run(1'b1, 1'b1);
            run(1'b0, 1'b1);
        end
        #1;
        check("prescale_gapped", 32'(count_w), 32'd4);
        run(1'b1, 1'b1);
        #1;
        check("prescale_next_step", 32'(count_w), 32'd5);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 15)));
        end

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
